seq_det_rr_sched: RTL
=====================

// Module: seq_det_rr_sched
// PURPOSE
//  Shares one 111010 Mealy overlapping-detector step function between NCH serial
//  bit streams. Round-robin arbiter picks one valid channel per cycle; per-channel
//  FSM context is saved/restored so each stream is detected independently.
//  Sits between serial front-ends and the event/interrupt logic.
// PARAMETERS
//  NCH   4  number of requesting channels (2..16)
//  CW    2  channel index width, $clog2(NCH)
//  CNTW  8  hit counter width (used only with SEQ_DET_HITCNT_EN)
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     asynchronous, active-high reset
//  ch_valid   in   NCH   channel i presents bit ch_bit[i]
//  ch_bit     in   NCH   serial data bit per channel
//  ch_clear   in   NCH   sync clear of channel i FSM context to S0
//  ch_ready   out  NCH   one-hot grant; bit consumed on this edge (combinational)
//  det_out    out  1     registered: pattern completed on det_ch last cycle
//  det_ch     out  CW    channel of the detection; holds value when det_out=0
//  hit_cnt    out  CNTW  total detections, saturating (SEQ_DET_HITCNT_EN only)
//  cnt_clr    in   1     sync clear of hit_cnt (SEQ_DET_HITCNT_EN only)
// BEHAVIOUR
//  - Reset: all contexts S0, rr pointer=0, det_out=0, det_ch=0, hit_cnt=0.
//    ch_ready=0 while rst=1. Reset mid-stream discards partial matches.
//  - Arbitration: eligible(i)=ch_valid[i]&~ch_clear[i]. Search starts at ptr,
//    wraps NCH-1->0; first eligible gets ch_ready. ptr <= grant+1 (mod NCH) on a
//    grant, unchanged otherwise. At most one grant per cycle; none if none eligible.
//  - Step (granted g, bit b), context st[g] in S0..S5 (prefix length matched):
//    S0:1->S1,0->S0  S1:1->S2,0->S0  S2:1->S3,0->S0  S3:1->S3,0->S4
//    S4:1->S5,0->S0  S5:0->S0+match, 1->S2 (overlap: "111011" keeps "11").
//  - Latency: 1 cycle. det_out<=match, det_ch<=g on the grant edge; det_out=0 on
//    cycles with no grant or no match.
//  - ch_clear[i] forces st[i]<=S0; takes priority over a bit on that channel
//    (channel not granted that cycle). Other channels unaffected.
//  - Ungranted channels keep context; stream bits are never dropped, only stalled.
// CONFIGURATION
//  SEQ_DET_HITCNT_EN defined: hit_cnt/cnt_clr ports exist; hit_cnt+=1 per det_out,
//   saturates at 2^CNTW-1; cnt_clr wins over a simultaneous increment.
//  Not defined: ports and counter absent; all other behaviour identical.
// STRUCTURE
//  seq_det_pkg: localparams S0..S5 (3-bit state encoding), PATTERN=6'b111010,
//   typedef for state.
//  Sub-module seq_det_step: combinational (state,bit)->(next_state,match);
//   one instance shared by all channels. Top holds contexts, arbiter, outputs.
// TESTING
//  1 Ch0 only, bits 111010 111010 -> det_out=1, det_ch=0 one cycle after 6th and
//    12th bit; no other pulses.
//  2 Ch1 bits 1110111010 -> single det at 10th bit (overlap S5/1->S2 path).
//  3 All 4 valid continuously -> grants 0,1,2,3,0...; each channel fed 111010
//    detects after its 6th grant, det_ch=0..3 in order.
//  4 Ch2 sent 1110, rst pulsed async mid-cycle, then 10 -> no detection; full
//    111010 after reset -> detection.
//  5 Ch3 sent 11101, ch_clear[3]=1 with ch_valid[3]=1 -> ch_ready[3]=0, then 0 ->
//    no detection.
//  6 SEQ_DET_HITCNT_EN, CNTW=2: 5 detections -> hit_cnt 1,2,3,3,3; cnt_clr with
//    det_out -> 0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared definitions for the multi-channel 111010 detector.
//   state_t  - 3-bit encoding of the detector context (prefix length matched)
//   S0..S5   - context encodings, S<n> = first n pattern bits seen
//   PATTERN  - the detected sequence, oldest bit first (MSB)
package seq_det_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S0 = 3'd0;
  localparam state_t S1 = 3'd1;
  localparam state_t S2 = 3'd2;
  localparam state_t S3 = 3'd3;
  localparam state_t S4 = 3'd4;
  localparam state_t S5 = 3'd5;

  localparam logic [5:0] PATTERN = 6'b111010;

endpackage

// File: rtl/seq_det_step.sv
// seq_det_step: combinational step function of the overlapping Mealy
// detector for PATTERN. It holds no state; the caller supplies the channel
// context and stores the returned next context.
//   st_i    in  current context (S0..S5)
//   bit_i   in  incoming serial bit
//   nxt_o   out next context
//   match_o out pattern completed by this bit
module seq_det_step
  import seq_det_pkg::*;
(
  input  state_t st_i,
  input  logic   bit_i,
  output state_t nxt_o,
  output logic   match_o
);

  always_comb begin
    nxt_o   = S0;
    match_o = 1'b0;
    case (st_i)
      S0: nxt_o = bit_i ? S1 : S0;
      S1: nxt_o = bit_i ? S2 : S0;
      S2: nxt_o = bit_i ? S3 : S0;
      // "1111" still ends in "111"
      S3: nxt_o = bit_i ? S3 : S4;
      S4: nxt_o = bit_i ? S5 : S0;
      S5: begin
        // "111011" keeps "11"; a completed match leaves no reusable prefix
        if (bit_i) begin
          nxt_o = S2;
        end else begin
          nxt_o   = S0;
          match_o = 1'b1;
        end
      end
      default: nxt_o = S0;
    endcase
  end

endmodule

// File: rtl/seq_det_rr_sched.sv
// seq_det_rr_sched: one 111010 detector step shared round-robin between NCH
// serial streams. Each channel keeps its own saved context, so streams are
// detected independently; an ungranted channel simply stalls.
// Optional feature macro: SEQ_DET_HITCNT_EN (adds hit_cnt / cnt_clr).
//   clk       in  clock, rising edge
//   rst       in  asynchronous active-high reset
//   cnt_clr   in  sync clear of hit_cnt            (SEQ_DET_HITCNT_EN)
//   hit_cnt   out saturating detection count       (SEQ_DET_HITCNT_EN)
//   ch_valid  in  channel i presents ch_bit[i]
//   ch_bit    in  serial bit per channel
//   ch_clear  in  sync clear of channel i context
//   ch_ready  out one-hot grant, bit consumed at this edge
//   det_out   out registered detection pulse
//   det_ch    out channel of last detection (holds otherwise)
module seq_det_rr_sched
  import seq_det_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int CW   = 2,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
`ifdef SEQ_DET_HITCNT_EN
  input  logic            cnt_clr,
  output logic [CNTW-1:0] hit_cnt,
`endif
  input  logic [NCH-1:0]  ch_valid,
  input  logic [NCH-1:0]  ch_bit,
  input  logic [NCH-1:0]  ch_clear,
  output logic [NCH-1:0]  ch_ready,
  output logic            det_out,
  output logic [CW-1:0]   det_ch
);

  state_t [NCH-1:0] st_q, st_d;
  logic   [CW-1:0]  ptr_q, ptr_d;
  logic             det_q;
  logic   [CW-1:0]  det_ch_q;

  logic   [NCH-1:0] elig, gnt;
  logic             gnt_any, hi_found, lo_found;
  logic   [CW-1:0]  gnt_idx, hi_idx, lo_idx;
  state_t           step_nxt;
  logic             step_match, match_v;

  // Round-robin: the lowest eligible index at or above ptr wins, otherwise
  // the lowest eligible index overall (wrap-around).
  always_comb begin
    elig     = ch_valid & ~ch_clear;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (elig[i] && !hi_found && (CW'(i) >= ptr_q)) begin
        hi_found = 1'b1;
        hi_idx   = CW'(i);
      end
      if (elig[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = CW'(i);
      end
    end
    gnt_any = (hi_found | lo_found) & ~rst;
    gnt_idx = hi_found ? hi_idx : lo_idx;
    for (int i = 0; i < NCH; i++) begin
      gnt[i] = gnt_any && (gnt_idx == CW'(i));
    end
  end

  assign ch_ready = gnt;

  seq_det_step u_step (
    .st_i    (st_q[gnt_idx]),
    .bit_i   (ch_bit[gnt_idx]),
    .nxt_o   (step_nxt),
    .match_o (step_match)
  );

  assign match_v = gnt_any & step_match;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
    end
    for (int i = 0; i < NCH; i++) begin
      st_d[i] = st_q[i];
      if (ch_clear[i]) begin
        st_d[i] = S0;
      end else if (gnt[i]) begin
        st_d[i] = step_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) st_q[i] <= S0;
      ptr_q    <= '0;
      det_q    <= 1'b0;
      det_ch_q <= '0;
    end else begin
      st_q  <= st_d;
      ptr_q <= ptr_d;
      det_q <= match_v;
      if (match_v) det_ch_q <= gnt_idx;
    end
  end

  assign det_out = det_q;
  assign det_ch  = det_ch_q;

`ifdef SEQ_DET_HITCNT_EN
  logic [CNTW-1:0] hit_q;

  // Counts each det_out pulse as it is presented; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q <= '0;
    end else if (cnt_clr) begin
      hit_q <= '0;
    end else if (det_q && (hit_q != '1)) begin
      hit_q <= hit_q + CNTW'(1);
    end
  end

  assign hit_cnt = hit_q;
`else
  logic unused_cntw;
  assign unused_cntw = (CNTW > 0);
`endif

endmodule
